spi_slave_core: RTL

- SPI target (slave) end of the serial link whose master-side SCK comes from the SPI clock generator.
- Samples externally driven SCK/SS_N/MOSI in the PCLK domain and deserialises MOSI into bytes for the APB register block.
- Serialises a buffered transmit byte onto MISO.
- Supports all four CPOL/CPHA modes and MSB- or LSB-first ordering.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_slave_core.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target core.
// Used by spi_sync_edge and spi_slave_core.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Wide all-ones pattern; slice to the frame width where used.
  localparam logic [63:0] IDLE_FILL = '1;

  // Sample on the rising SCK edge when CPOL==CPHA, otherwise on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus registered rise/fall pulses.
// Edge pulses appear SYNC_STAGES+1 PCLK cycles after the pin changes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic                   sync;

  assign sync = chain[SYNC_STAGES-1];

  // NOTE: non-blocking assignments so every flop in the chain samples its pre-edge neighbour.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= sync;
      rise  <= sync & ~prev;
      fall  <= ~sync & prev;
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// SPI target: oversamples SCK/SS_N/MOSI in the PCLK domain, deserialises MOSI
// into RX_DATA and serialises a buffered transmit byte onto MISO (all CPOL/CPHA modes).
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  LSBFE,
  input  logic                  SCK_IN,
  input  logic                  SS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_WR,
  output logic                  TX_EMPTY,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_FULL,
  input  logic                  RX_RD,
  output logic                  OVERRUN,
  output logic                  BUSY
);

  localparam int                    CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] FILL     = IDLE_FILL[DATA_WIDTH-1:0];

  state_t                  state;
  state_t                  state_nxt;
  logic                    sck_rise;
  logic                    sck_fall;
  logic                    ss_rise;
  logic                    ss_fall;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    mosi_s;
  logic [DATA_WIDTH-1:0]   tx_buf;
  logic [DATA_WIDTH-1:0]   tx_sr;
  logic [DATA_WIDTH-1:0]   rx_sr;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    first_edge;
  logic                    any_done;
  logic                    rx_done;
  logic                    enter;
  logic                    leave;
  logic                    in_frame;
  logic                    sample_ev;
  logic                    shift_ev;
  logic                    tx_reload;
  logic                    tx_load;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sck_sync (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .din    (SCK_IN),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  // SS_N idles high, so reset its synchroniser high to avoid a phantom select edge.
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_ss_sync (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .din    (SS_N),
    .rise   (ss_rise),
    .fall   (ss_fall)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Frame state machine: select edges alone move it, so mode changes cannot wedge it.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (ss_fall) state_nxt = ACTIVE;
      ACTIVE:  if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter     = (state == IDLE)   && ss_fall;
  assign leave     = (state == ACTIVE) && ss_rise;
  assign in_frame  = (state == ACTIVE) && !ss_rise;
  assign sample_ev = in_frame && (sample_on_rise(CPOL, CPHA) ? sck_rise : sck_fall);
  assign shift_ev  = in_frame && (sample_on_rise(CPOL, CPHA) ? sck_fall : sck_rise);
  assign tx_reload = shift_ev && !first_edge && (bit_cnt == '0) && any_done;
  assign tx_load   = enter || tx_reload;

  // Transmit buffer: a write in the same cycle as a load survives the load.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_buf   <= '0;
      TX_EMPTY <= 1'b1;
    end else begin
      if (TX_WR) begin
        tx_buf   <= TX_DATA;
        TX_EMPTY <= 1'b0;
      end else if (tx_load) begin
        TX_EMPTY <= 1'b1;
      end
    end
  end

  // Shift registers and bit counter.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      first_edge <= 1'b0;
      any_done   <= 1'b0;
      rx_done    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (enter) begin
        tx_sr      <= TX_EMPTY ? FILL : tx_buf;
        bit_cnt    <= '0;
        first_edge <= CPHA;
        any_done   <= 1'b0;
      end else if (leave) begin
        bit_cnt    <= '0;
        first_edge <= 1'b0;
        any_done   <= 1'b0;
      end else if (sample_ev) begin
        rx_sr <= LSBFE ? {mosi_s, rx_sr[DATA_WIDTH-1:1]}
                       : {rx_sr[DATA_WIDTH-2:0], mosi_s};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_done  <= 1'b1;
          any_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (shift_ev) begin
        if (first_edge) begin
          first_edge <= 1'b0;
        end else if (tx_reload) begin
          tx_sr <= TX_EMPTY ? FILL : tx_buf;
        end else begin
          tx_sr <= LSBFE ? {1'b0, tx_sr[DATA_WIDTH-1:1]}
                         : {tx_sr[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  // Receive holding register; a completing byte takes priority over a read strobe.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      RX_DATA <= '0;
      RX_FULL <= 1'b0;
      OVERRUN <= 1'b0;
    end else if (rx_done) begin
      RX_DATA <= rx_sr;
      RX_FULL <= 1'b1;
      OVERRUN <= RX_RD ? 1'b0 : (OVERRUN | RX_FULL);
    end else if (RX_RD) begin
      RX_FULL <= 1'b0;
      OVERRUN <= 1'b0;
    end
  end

  assign BUSY    = (state == ACTIVE);
  assign MISO_OE = BUSY;
  assign MISO    = BUSY & (LSBFE ? tx_sr[0] : tx_sr[DATA_WIDTH-1]);

endmodule
